// File: rtl/ibuf_loader_pkg.sv
// Shared definitions for ibuf_loader: FSM state encoding and default widths.
package ibuf_loader_pkg;

  localparam int unsigned DefMemDataWidth = 64;
  localparam int unsigned DefMemAddrWidth = 12;
  localparam int unsigned DefCountW       = 16;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StLoad = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/ibuf_loader.sv
// Stream-to-buffer write loader: writes num_words beats from base_addr upward.
// Optional s_last consistency checking is enabled by IBUF_LOADER_LAST_CHECK_EN.
module ibuf_loader
  import ibuf_loader_pkg::*;
#(
  parameter int unsigned MEM_DATA_WIDTH = DefMemDataWidth,
  parameter int unsigned MEM_ADDR_WIDTH = DefMemAddrWidth,
  parameter int unsigned COUNT_W        = DefCountW
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [MEM_ADDR_WIDTH-1:0] base_addr,
  input  logic [COUNT_W-1:0]        num_words,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [MEM_DATA_WIDTH-1:0] s_data,
  input  logic                      s_last,
  output logic                      mem_write_req,
  output logic [MEM_ADDR_WIDTH-1:0] mem_write_addr,
  output logic [MEM_DATA_WIDTH-1:0] mem_write_data,
  output logic                      busy,
  output logic                      done,
  output logic                      err
);

  state_e                    state_q, state_d;
  logic [MEM_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [COUNT_W-1:0]        cnt_q, cnt_d;
  logic [COUNT_W-1:0]        num_q, num_d;
  logic                      wr_req_q, wr_req_d;
  logic [MEM_ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [MEM_DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic                      ready_q, ready_d;
  logic                      last_beat;

`ifdef IBUF_LOADER_LAST_CHECK_EN
  logic err_q, err_d;
`endif

  assign last_beat = (cnt_q == num_q - COUNT_W'(1));

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    num_d     = num_q;
    wr_req_d  = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    done_d    = 1'b0;
`ifdef IBUF_LOADER_LAST_CHECK_EN
    err_d     = err_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (num_words != '0) begin
            addr_d  = base_addr;
            num_d   = num_words;
            cnt_d   = '0;
            state_d = StLoad;
`ifdef IBUF_LOADER_LAST_CHECK_EN
            err_d   = 1'b0;
`endif
          end else begin
            // Empty tile: report completion without ever leaving idle.
            done_d = 1'b1;
          end
        end
      end
      StLoad: begin
        if (s_valid) begin
          wr_req_d  = 1'b1;
          wr_addr_d = addr_q;
          wr_data_d = s_data;
          addr_d    = addr_q + MEM_ADDR_WIDTH'(1);
          cnt_d     = cnt_q + COUNT_W'(1);
          if (last_beat) begin
            state_d = StDone;
            done_d  = 1'b1;
          end
`ifdef IBUF_LOADER_LAST_CHECK_EN
          if (s_last != last_beat) begin
            err_d = 1'b1;
          end
`endif
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    busy_d  = (state_d != StIdle);
    ready_d = (state_d == StLoad);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      cnt_q     <= '0;
      num_q     <= '0;
      wr_req_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      num_q     <= num_d;
      wr_req_q  <= wr_req_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ready_q   <= ready_d;
    end
  end

`ifdef IBUF_LOADER_LAST_CHECK_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end
  assign err = err_q;
`else
  logic unused_s_last;
  assign unused_s_last = s_last;
  assign err           = 1'b0;
`endif

  assign s_ready        = ready_q;
  assign mem_write_req  = wr_req_q;
  assign mem_write_addr = wr_addr_q;
  assign mem_write_data = wr_data_q;
  assign busy           = busy_q;
  assign done           = done_q;

endmodule

// File: doc/ibuf_loader.md
# ibuf_loader

Upstream feeder for the input buffer: accepts a valid/ready stream of memory beats (one `MEM_DATA_WIDTH` word per beat) and converts it into the buffer's write-port protocol (`mem_write_req`/`mem_write_addr`/`mem_write_data`) for a programmed number of words, starting at a programmed base address. A single start pulse launches each tile load. `done` reports completion to the controller, and `s_ready` provides backpressure to the memory interface.

## Interface
Parameters:
- `MEM_DATA_WIDTH`, 64, width of one stream beat and one buffer write word
- `MEM_ADDR_WIDTH`, 12, buffer write address width; must equal the buffer's `BUF_ADDR_WIDTH + BUF_ID_W`
- `COUNT_W`, 16, width of the word-count field

Ports:
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-high reset
- `start`  in  1  one-cycle load request; sampled only in IDLE
- `base_addr`  in  MEM_ADDR_WIDTH  first write address; sampled with `start`
- `num_words`  in  COUNT_W  number of beats to load; sampled with `start`
- `s_valid`  in  1  stream beat valid
- `s_ready`  out  1  stream beat ready
- `s_data`  in  MEM_DATA_WIDTH  stream beat data
- `s_last`  in  1  producer's end-of-tile marker
- `mem_write_req`  out  1  buffer write strobe
- `mem_write_addr`  out  MEM_ADDR_WIDTH  buffer write address
- `mem_write_data`  out  MEM_DATA_WIDTH  buffer write data
- `busy`  out  1  high in LOAD and DONE
- `done`  out  1  one-cycle completion pulse
- `err`  out  1  sticky `s_last` mismatch flag

## Operation
- States: IDLE, LOAD, DONE.
- IDLE:
  - `start` with `num_words != 0`: latch `base_addr` into the address counter, latch `num_words`, clear the beat counter and `err`, go to LOAD.
  - `start` with `num_words == 0`: assert `done` next cycle and stay in IDLE; no writes are issued.
- LOAD:
  - `s_ready = 1`; a beat is accepted on `s_valid && s_ready`.
  - Each accepted beat is written at the current address. The address then increments by 1 modulo 2^MEM_ADDR_WIDTH, wrapping from all-ones to 0 silently. The beat counter increments.
  - When the accepted beat is beat `num_words-1`, go to DONE.
  - `s_valid` low inserts bubbles; no write is issued for that cycle.
- DONE: lasts exactly one cycle with `done = 1`, `s_ready = 0`; then go to IDLE.
- `start` outside IDLE is ignored; it is neither queued nor does it alter the latched fields.
- `s_ready` is 0 in IDLE and DONE; beats presented then are not consumed.
- Count arithmetic is unsigned, COUNT_W wide; the maximum tile is 2^COUNT_W−1 beats.

## Timing
- Reset values: `s_ready`, `mem_write_req`, `busy`, `done`, `err` = 0; `mem_write_addr`, `mem_write_data` = 0; state = IDLE.
- Write outputs are registered: a beat accepted in cycle t appears on `mem_write_*` in cycle t+1 with `mem_write_req = 1` for exactly one cycle.
- `busy` rises the cycle after `start`. The first beat can be accepted in that same cycle.
- Throughput is one beat per cycle in LOAD.
- Final beat accepted in cycle t:
  - The final write and `done` are both asserted in cycle t+1.
  - `busy` is low and a new `start` is accepted from cycle t+2.
- Zero-count start in cycle t: `done` in cycle t+1, `busy` stays 0.
- Reset asserted mid-load: all state clears asynchronously. A write registered but not yet presented is dropped. The partially loaded buffer contents are not defined.

## Configuration
- `IBUF_LOADER_LAST_CHECK_EN` defined:
  - `err` is set if `s_last` is 1 on an accepted beat other than beat `num_words-1`, or 0 on that final beat.
  - `err` stays set until the next accepted `start`.
  - Loading continues by count regardless of `err`.
- Not defined: `s_last` is ignored and `err` is tied to 0.

## Structure
- Shared package/header `ibuf_loader_pkg`: state encodings (IDLE=2'd0, LOAD=2'd1, DONE=2'd2) and the default width constants.
- Single module, no sub-modules: the FSM, address counter, beat counter and output register are all inline.

## Test plan
- Normal load: `start`, `base_addr=0x010`, `num_words=4`, four back-to-back beats D0..D3 with `s_last` on D3 -> writes at 0x010..0x013 on consecutive cycles; `done` coincides with the 0x013 write; `err=0`.
- Bubbles: `num_words=3`, `s_valid` pattern 1,0,0,1,1 -> exactly 3 writes with contiguous addresses; no `mem_write_req` during the gaps.
- Wrap: `MEM_ADDR_WIDTH=12`, `base_addr=0xFFE`, `num_words=4` -> writes at 0xFFE, 0xFFF, 0x000, 0x001.
- Zero count and ignored start: `start` with `num_words=0` -> `done` the next cycle, no writes, `busy=0`. A second `start` during an active LOAD -> no effect on address or count.
- Last check (macro defined): `num_words=4`, `s_last` on beat 1 -> `err=1` the cycle after; all 4 writes are still issued; the next `start` clears `err`. Without the macro, `err` stays 0.
- Reset mid-load: assert `reset` after 2 of 5 beats -> all outputs 0 immediately, state IDLE; a new `start` afterwards loads from its own `base_addr` correctly.
